// File: rtl/bcrypt_core_sequencer.sv
// Host-side sequencer that steps every bcrypt core through CLEAR, LOAD, COMPUTE and STORE,
// waiting for all cores to report the matching done code before each advance.
module bcrypt_core_sequencer #(
    parameter int unsigned NUM_CORES      = 2,
    parameter int unsigned CLEAR_CYCLES   = 2,
    parameter int unsigned TIMEOUT_CYCLES = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    err_clr,
    output logic [32*NUM_CORES-1:0] start,
    input  logic [32*NUM_CORES-1:0] done,
    output logic                    busy,
    output logic [1:0]              phase,
    output logic [NUM_CORES-1:0]    done_mask,
    output logic                    run_done,
    output logic                    err
);

    typedef enum logic [2:0] {
        S_IDLE, S_CLEAR, S_LOAD, S_COMPUTE, S_STORE, S_FINISH, S_ERROR
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] timer_q, timer_d;
    logic [1:0]  phase_q, phase_d;
    logic        cmd_ready_q, cmd_ready_d;
    logic        busy_q, busy_d;
    logic        run_done_q, run_done_d;
    logic        err_q, err_d;

    logic [31:0] expected;
    logic        allMatch;
    logic        inWait;
    logic        clearHeld;
    logic        timedOut;

    always_comb begin
        expected = 32'h0;
        case (state_q)
            S_LOAD:    expected = 32'h1;
            S_COMPUTE: expected = 32'h2;
            S_STORE:   expected = 32'hFF;
            default:   expected = 32'h0;
        endcase
    end

    // Full 32-bit compare per core; a partial or unrelated status word never counts.
    always_comb begin
        done_mask = '0;
        for (int k = 0; k < NUM_CORES; k++) begin
            done_mask[k] = (done[32*k +: 32] == expected);
        end
    end

    assign allMatch  = &done_mask;
    assign inWait    = (state_q == S_CLEAR) || (state_q == S_LOAD) ||
                       (state_q == S_COMPUTE) || (state_q == S_STORE);
    assign clearHeld = (timer_q >= CLEAR_CYCLES - 1);
    assign timedOut  = (TIMEOUT_CYCLES != 0) && (timer_q >= TIMEOUT_CYCLES - 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            timer_q     <= '0;
            phase_q     <= 2'd0;
            cmd_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            run_done_q  <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            phase_q     <= phase_d;
            cmd_ready_q <= cmd_ready_d;
            busy_q      <= busy_d;
            run_done_q  <= run_done_d;
            err_q       <= err_d;
        end
    end

    // A match in the same cycle as a timeout takes priority and advances the run.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (cmd_valid) state_d = S_CLEAR;
            S_CLEAR:   if (clearHeld && allMatch) state_d = S_LOAD;
                       else if (timedOut) state_d = S_ERROR;
            S_LOAD:    if (allMatch) state_d = S_COMPUTE;
                       else if (timedOut) state_d = S_ERROR;
            S_COMPUTE: if (allMatch) state_d = S_STORE;
                       else if (timedOut) state_d = S_ERROR;
            S_STORE:   if (allMatch) state_d = S_FINISH;
                       else if (timedOut) state_d = S_ERROR;
            S_FINISH:  state_d = S_IDLE;
            S_ERROR:   if (err_clr) state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase

        timer_d = timer_q;
        if (state_d != state_q) begin
            timer_d = '0;
        end else if (inWait && (timer_q != '1)) begin
            timer_d = timer_q + 32'd1;
        end
    end

    always_comb begin
        phase_d     = 2'd0;
        cmd_ready_d = 1'b0;
        busy_d      = 1'b1;
        run_done_d  = 1'b0;
        err_d       = 1'b0;
        case (state_d)
            S_IDLE:    begin cmd_ready_d = 1'b1; busy_d = 1'b0; end
            S_LOAD:    phase_d = 2'd1;
            S_COMPUTE: phase_d = 2'd2;
            S_STORE:   phase_d = 2'd3;
            S_FINISH:  run_done_d = 1'b1;
            S_ERROR:   begin busy_d = 1'b0; err_d = 1'b1; end
            default:   phase_d = 2'd0;
        endcase
    end

    assign start     = {NUM_CORES{{30'b0, phase_q}}};
    assign phase     = phase_q;
    assign cmd_ready = cmd_ready_q;
    assign busy      = busy_q;
    assign run_done  = run_done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_bcrypt_core_sequencer.sv
// Bench for bcrypt_core_sequencer: stub cores with randomized reply delays driven from a
// run-level reference model; every cycle the outputs are checked against that model.
module tb_bcrypt_core_sequencer;

    localparam int NC = 2;
    localparam int CC = 2;
    localparam int TO = 100;

    localparam int M_IDLE    = 0;
    localparam int M_CLEAR   = 1;
    localparam int M_LOAD    = 2;
    localparam int M_COMPUTE = 3;
    localparam int M_STORE   = 4;
    localparam int M_FINISH  = 5;
    localparam int M_ERROR   = 6;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          err_clr;
    logic [63:0]   start;
    logic [63:0]   done;
    logic          busy;
    logic [1:0]    phase;
    logic [NC-1:0] done_mask;
    logic          run_done;
    logic          err;

    always #5 clk = ~clk;

    bcrypt_core_sequencer #(
        .NUM_CORES(NC), .CLEAR_CYCLES(CC), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .err_clr(err_clr), .start(start), .done(done), .busy(busy), .phase(phase),
        .done_mask(done_mask), .run_done(run_done), .err(err)
    );

    int          vectors = 0;
    int          miscompares = 0;
    int          runsDone = 0;
    int          mState;
    int unsigned mTimer;
    logic [31:0] doneW [NC];
    int unsigned dly [NC][4];
    logic        preEn [NC][4];
    logic [31:0] preVal [NC];
    logic        cmdValid;
    logic        errClr;
    logic [31:0] statusCode [7] = '{32'h0, 32'h0, 32'h1, 32'h2, 32'hFF, 32'h0, 32'h0};
    int          cmdCode [7]    = '{0, 0, 1, 2, 3, 0, 0};

    function automatic bit isWait(input int s);
        return (s >= M_CLEAR) && (s <= M_STORE);
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic checkRegistered();
        logic [63:0] expStart;
        for (int k = 0; k < NC; k++) expStart[32*k +: 32] = 32'(cmdCode[mState]);
        checkOutput("start", start, expStart);
        checkOutput("phase", 64'(phase), 64'(cmdCode[mState]));
        checkOutput("busy", 64'(busy), 64'(mState >= M_CLEAR && mState <= M_FINISH));
        checkOutput("cmd_ready", 64'(cmd_ready), 64'(mState == M_IDLE));
        checkOutput("run_done", 64'(run_done), 64'(mState == M_FINISH));
        checkOutput("err", 64'(err), 64'(mState == M_ERROR));
    endtask

    // One clock: stub cores update from the model, mask checked, model steps, outputs checked.
    task automatic applyStimulus();
        int            nxt;
        bit            allM;
        logic [NC-1:0] expMask;
        if (isWait(mState)) begin
            for (int k = 0; k < NC; k++) begin
                if (mTimer >= dly[k][mState-M_CLEAR]) doneW[k] = statusCode[mState];
                else if (preEn[k][mState-M_CLEAR]) doneW[k] = preVal[k];
            end
        end
        for (int k = 0; k < NC; k++) done[32*k +: 32] = doneW[k];
        cmd_valid = cmdValid;
        err_clr   = errClr;
        #1;
        allM = 1'b1;
        for (int k = 0; k < NC; k++) begin
            expMask[k] = (doneW[k] == statusCode[mState]);
            allM = allM && expMask[k];
        end
        checkOutput("done_mask", 64'(done_mask), 64'(expMask));
        nxt = mState;
        if (mState == M_IDLE) begin
            if (cmdValid) nxt = M_CLEAR;
        end else if (isWait(mState)) begin
            if (allM && (mState != M_CLEAR || mTimer + 1 >= CC)) nxt = mState + 1;
            else if (mTimer + 1 >= TO) nxt = M_ERROR;
        end else if (mState == M_FINISH) begin
            nxt = M_IDLE;
        end else if (errClr) begin
            nxt = M_IDLE;
        end
        if (nxt != mState) mTimer = 0;
        else if (isWait(mState) && mTimer != 32'hFFFF_FFFF) mTimer++;
        if (nxt == M_FINISH) runsDone++;
        mState = nxt;
        @(posedge clk);
        #1;
        checkRegistered();
    endtask

    // Launch one run and follow it until it returns to IDLE or lands in ERROR.
    task automatic runOne(input int budget);
        int n = 0;
        cmdValid = 1'b1;
        applyStimulus();
        cmdValid = 1'b0;
        while (mState != M_IDLE && mState != M_ERROR && n < budget) begin
            applyStimulus();
            n++;
        end
        if (n >= budget) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL run_budget: observed %0d cycles required below %0d", n, budget);
        end
    endtask

    task automatic setDelays(input int unsigned c, input int unsigned l, input int unsigned p,
                             input int unsigned s);
        for (int k = 0; k < NC; k++) begin
            dly[k] = '{c, l, p, s};
            preEn[k] = '{1'b0, 1'b0, 1'b0, 1'b0};
        end
    endtask

    initial begin
        int startRuns;
        int n;
        rst_n = 1'b0;
        cmd_valid = 1'b0;
        err_clr = 1'b0;
        done = '0;
        cmdValid = 1'b0;
        errClr = 1'b0;
        mState = M_IDLE;
        mTimer = 0;
        for (int k = 0; k < NC; k++) begin
            doneW[k] = 32'h0;
            preVal[k] = 32'h0;
        end
        setDelays(0, 5, 20, 8);
        #12;
        checkRegistered();
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Basic run, then skewed completion in COMPUTE.
        runOne(500);
        applyStimulus();
        dly[0][2] = 10;
        dly[1][2] = 50;
        runOne(500);
        applyStimulus();

        // Stale STORE status during CLEAR and an unrelated code during LOAD.
        setDelays(0, 5, 4, 3);
        dly[0][0] = 6;
        dly[0][1] = 15;
        preEn[0][1] = 1'b1;
        preVal[0] = 32'h3;
        runOne(500);
        applyStimulus();

        // cmd_valid held across two back-to-back runs.
        setDelays(1, 3, 6, 2);
        startRuns = runsDone;
        cmdValid = 1'b1;
        n = 0;
        while (runsDone < startRuns + 2 && n < 500) begin
            applyStimulus();
            n++;
        end
        cmdValid = 1'b0;
        while (mState != M_IDLE && n < 600) begin
            applyStimulus();
            n++;
        end
        checkOutput("held_runs", 64'(runsDone - startRuns), 64'd2);

        // Asynchronous reset in the middle of COMPUTE.
        setDelays(0, 2, 40, 2);
        cmdValid = 1'b1;
        applyStimulus();
        cmdValid = 1'b0;
        n = 0;
        while ((mState != M_COMPUTE || mTimer < 5) && n < 200) begin
            applyStimulus();
            n++;
        end
        #2;
        rst_n = 1'b0;
        mState = M_IDLE;
        mTimer = 0;
        for (int k = 0; k < NC; k++) doneW[k] = 32'h0;
        done = '0;
        #1;
        checkRegistered();
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        setDelays(0, 4, 7, 3);
        runOne(500);

        // Timeout in STORE, ignored cmd_valid in ERROR, then err_clr.
        dly[1][3] = 1000;
        runOne(500);
        checkOutput("timeout_state", 64'(mState), 64'(M_ERROR));
        cmdValid = 1'b1;
        repeat (3) applyStimulus();
        cmdValid = 1'b0;
        errClr = 1'b1;
        applyStimulus();
        errClr = 1'b0;
        repeat (2) applyStimulus();

        // Randomized runs, some of which time out in a wait state.
        for (int r = 0; r < 12; r++) begin
            for (int k = 0; k < NC; k++) begin
                for (int p = 0; p < 4; p++) begin
                    dly[k][p] = $urandom_range(0, 40);
                    preEn[k][p] = ($urandom_range(0, 3) == 0);
                end
                preVal[k] = $urandom | 32'h100;
            end
            if ($urandom_range(0, 3) == 0) dly[$urandom_range(0, NC-1)][$urandom_range(1, 3)] = 130;
            runOne(800);
            if (mState == M_ERROR) begin
                repeat ($urandom_range(0, 3)) applyStimulus();
                errClr = 1'b1;
                applyStimulus();
                errClr = 1'b0;
            end
            repeat ($urandom_range(0, 2)) applyStimulus();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
